// File: rtl/lsu_pkg.sv
// Shared types for the memory stage: load-size encodings, FSM states and the
// M stage register layout.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } lsu_state_e;

   // res doubles as the word-aligned bus address for loads and stores
   typedef struct packed {
      logic        valid;
      logic        is_load;
      logic        is_store;
      logic [1:0]  shift;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] res;
   } mstage_t;

endpackage

// File: rtl/ld_align.sv
// Load data alignment: shifts the addressed bytes down and sign/zero-extends.
module ld_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  shift,
   input  logic [1:0]  sz,
   input  logic        uns,
   output logic [31:0] result
);

   logic [31:0] v;

   always_comb begin
      v = rdata >> {shift, 3'b000};
      case (sz)
         SZ_B:    result = {{24{~uns & v[7]}}, v[7:0]};
         SZ_H:    result = {{16{~uns & v[15]}}, v[15:0]};
         default: result = v;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage / load-store unit: M stage register, req/gnt/rvalid bus FSM,
// store byte-lane encoding and forwarding of the stage result.
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ext_stall,
   input  logic        valid_EX,
   input  logic        is_load_EX,
   input  logic        is_store_EX,
   input  logic        trap_EX,
   input  logic [31:0] res_EX,
   input  logic [1:0]  ldshift_EX,
   input  logic [1:0]  ldsz_EX,
   input  logic        ld_unsigned_EX,
   input  logic [31:0] x2_EX,
   input  logic [4:0]  rd_EX,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  rd_MEM,
   output logic [31:0] res_MEM,
   output logic        stall_req
);

   lsu_state_e  state_q, state_d;
   mstage_t     m_q, m_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] ld_data;
   logic        advance;
   lsu_state_e  cap_state;

   function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] shift);
      case (sz)
         SZ_B:    store_be = 4'b0001 << shift;
         SZ_H:    store_be = 4'b0011 << shift;
         default: store_be = 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] x2);
      case (sz)
         SZ_B:    store_wdata = {4{x2[7:0]}};
         SZ_H:    store_wdata = {2{x2[15:0]}};
         default: store_wdata = x2;
      endcase
   endfunction

   ld_align u_ld_align (
      .rdata  (mem_rdata),
      .shift  (m_q.shift),
      .sz     (m_q.sz),
      .uns    (m_q.uns),
      .result (ld_data)
   );

   always_comb begin
      stall_req = ((state_q == ST_REQ) && !(m_q.is_store && mem_gnt)) ||
                  ((state_q == ST_WAIT) && !mem_rvalid);
      advance   = !ext_stall && !stall_req;
      cap_state = (valid_EX && !trap_EX && (is_load_EX || is_store_EX)) ? ST_REQ : ST_IDLE;
   end

   // Stage register capture; traps and invalid slots become bubbles
   always_comb begin
      m_d = m_q;
      if (advance) begin
         m_d.valid    = valid_EX && !trap_EX;
         m_d.is_load  = valid_EX && !trap_EX && is_load_EX;
         m_d.is_store = valid_EX && !trap_EX && is_store_EX;
         m_d.shift    = ldshift_EX;
         m_d.sz       = ldsz_EX;
         m_d.uns      = ld_unsigned_EX;
         m_d.wdata    = x2_EX;
         m_d.rd       = (valid_EX && !trap_EX) ? rd_EX : 5'd0;
         m_d.res      = res_EX;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: if (advance) state_d = cap_state;
         ST_REQ: begin
            if (mem_gnt) begin
               if (!m_q.is_store)  state_d = ST_WAIT;
               else if (advance)   state_d = cap_state;
               else                state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (ext_stall) begin
                  state_d = ST_HOLD;
                  hold_d  = ld_data;
               end else begin
                  state_d = cap_state;
               end
            end
         end
         ST_HOLD: if (!ext_stall) state_d = cap_state;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (state_q == ST_REQ);
      mem_we    = mem_req && m_q.is_store;
      mem_addr  = mem_req ? m_q.res : 32'd0;
      mem_be    = 4'd0;
      mem_wdata = 32'd0;
      if (mem_req) mem_be = m_q.is_store ? store_be(m_q.sz, m_q.shift) : 4'hF;
      if (mem_we)  mem_wdata = store_wdata(m_q.sz, m_q.wdata);

      rd_MEM  = 5'd0;
      res_MEM = 32'd0;
      if (m_q.valid && !m_q.is_load && !m_q.is_store) begin
         rd_MEM  = m_q.rd;
         res_MEM = m_q.res;
      end else if (m_q.valid && m_q.is_load) begin
         if (state_q == ST_WAIT && mem_rvalid) begin
            rd_MEM  = m_q.rd;
            res_MEM = ld_data;
         end else if (state_q == ST_HOLD) begin
            rd_MEM  = m_q.rd;
            res_MEM = hold_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         m_q.valid    <= 1'b0;
         m_q.is_load  <= 1'b0;
         m_q.is_store <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
      end
   end

   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed cycle-table bench for mem_lsu plus a reset-during-access sequence.
module tb_mem_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ext_stall, valid_EX, is_load_EX, is_store_EX, trap_EX;
   logic [31:0] res_EX, x2_EX;
   logic [1:0]  ldshift_EX, ldsz_EX;
   logic        ld_unsigned_EX;
   logic [4:0]  rd_EX;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic [4:0]  rd_MEM;
   logic [31:0] res_MEM;
   logic        stall_req;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk(clk), .reset_n(reset_n), .ext_stall(ext_stall), .valid_EX(valid_EX),
      .is_load_EX(is_load_EX), .is_store_EX(is_store_EX), .trap_EX(trap_EX),
      .res_EX(res_EX), .ldshift_EX(ldshift_EX), .ldsz_EX(ldsz_EX),
      .ld_unsigned_EX(ld_unsigned_EX), .x2_EX(x2_EX), .rd_EX(rd_EX),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .rd_MEM(rd_MEM), .res_MEM(res_MEM), .stall_req(stall_req)
   );

   typedef struct packed {
      logic vld, ld, st, trap;
      logic [31:0] res;
      logic [1:0] sh, sz;
      logic uns;
      logic [31:0] x2;
      logic [4:0] rd;
   } ex_t;
   typedef struct packed {
      logic stl, gnt, rv;
      logic [31:0] rdata;
   } bus_t;
   typedef struct packed {
      logic req, we;
      logic [3:0] be;
      logic [31:0] addr, wdata;
      logic [4:0] rd;
      logic [31:0] res;
      logic stall;
   } exp_t;
   typedef struct packed {
      ex_t x;
      bus_t b;
      exp_t e;
   } vec_t;

   vec_t vecs[$];

   function automatic ex_t nop();
      ex_t x = '0;
      return x;
   endfunction
   function automatic ex_t alu(input logic [31:0] r, input logic [4:0] d);
      ex_t x = '0;
      x.vld = 1'b1; x.res = r; x.rd = d;
      return x;
   endfunction
   function automatic ex_t ldx(input logic [31:0] a, input logic [1:0] sh, input logic [1:0] sz,
                               input logic uns, input logic [4:0] d);
      ex_t x = '0;
      x.vld = 1'b1; x.ld = 1'b1; x.res = a; x.sh = sh; x.sz = sz; x.uns = uns; x.rd = d;
      return x;
   endfunction
   function automatic ex_t stx(input logic [31:0] a, input logic [1:0] sh, input logic [1:0] sz,
                               input logic [31:0] x2);
      ex_t x = '0;
      x.vld = 1'b1; x.st = 1'b1; x.res = a; x.sh = sh; x.sz = sz; x.x2 = x2;
      return x;
   endfunction
   function automatic bus_t bus(input logic stl, input logic gnt, input logic rv, input logic [31:0] rd);
      bus_t b;
      b.stl = stl; b.gnt = gnt; b.rv = rv; b.rdata = rd;
      return b;
   endfunction
   function automatic exp_t ereq(input logic we, input logic [3:0] be, input logic [31:0] a,
                                 input logic [31:0] wd, input logic stall);
      exp_t e = '0;
      e.req = 1'b1; e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.stall = stall;
      return e;
   endfunction
   function automatic exp_t eout(input logic [4:0] d, input logic [31:0] r, input logic stall);
      exp_t e = '0;
      e.rd = d; e.res = r; e.stall = stall;
      return e;
   endfunction

   task automatic add(input ex_t x, input bus_t b, input exp_t e);
      vecs.push_back({x, b, e});
   endtask

   task automatic drive(input ex_t x, input bus_t b);
      valid_EX = x.vld; is_load_EX = x.ld; is_store_EX = x.st; trap_EX = x.trap;
      res_EX = x.res; ldshift_EX = x.sh; ldsz_EX = x.sz; ld_unsigned_EX = x.uns;
      x2_EX = x.x2; rd_EX = x.rd;
      ext_stall = b.stl; mem_gnt = b.gnt; mem_rvalid = b.rv; mem_rdata = b.rdata;
   endtask

   task automatic chk(input int row, input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL row %0d %s: got %h want %h", row, name, got, want);
      end
   endtask

   task automatic chk_all(input int row, input exp_t e);
      chk(row, "mem_req",   {31'd0, mem_req},   {31'd0, e.req});
      chk(row, "mem_we",    {31'd0, mem_we},    {31'd0, e.we});
      chk(row, "mem_be",    {28'd0, mem_be},    {28'd0, e.be});
      chk(row, "mem_addr",  mem_addr,           e.addr);
      chk(row, "mem_wdata", mem_wdata,          e.wdata);
      chk(row, "rd_MEM",    {27'd0, rd_MEM},    {27'd0, e.rd});
      chk(row, "res_MEM",   res_MEM,            e.res);
      chk(row, "stall_req", {31'd0, stall_req}, {31'd0, e.stall});
   endtask

   initial begin
      exp_t z;
      z = '0;
      // cycle table: EX inputs, bus inputs, expected outputs in that cycle
      add(alu(32'h1234, 5'd5),                        bus(0,0,0,0), z);
      add(nop(),                                      bus(0,0,0,0), eout(5'd5, 32'h1234, 0));
      add(stx(32'h100, 2'd3, SZ_B, 32'h000000AB),     bus(0,0,0,0), z);
      add(nop(),                                      bus(0,1,0,0), ereq(1, 4'b1000, 32'h100, 32'hABABABAB, 0));
      add(ldx(32'h200, 2'd2, SZ_H, 1'b0, 5'd7),       bus(0,0,0,0), z);
      add(alu(32'h55, 5'd9),                          bus(0,1,0,0), ereq(0, 4'hF, 32'h200, 32'h0, 1));
      add(alu(32'h55, 5'd9),                          bus(0,0,0,0), eout(5'd0, 32'h0, 1));
      add(alu(32'h55, 5'd9),                          bus(0,0,1,32'h80010000), eout(5'd7, 32'hFFFF8001, 0));
      add(stx(32'h300, 2'd0, SZ_W, 32'hDEADBEEF),     bus(0,0,0,0), eout(5'd9, 32'h55, 0));
      add(nop(),                                      bus(0,0,0,0), ereq(1, 4'hF, 32'h300, 32'hDEADBEEF, 1));
      add(nop(),                                      bus(1,0,0,0), ereq(1, 4'hF, 32'h300, 32'hDEADBEEF, 1));
      add(nop(),                                      bus(0,1,0,0), ereq(1, 4'hF, 32'h300, 32'hDEADBEEF, 0));
      add(stx(32'h400, 2'd2, SZ_H, 32'h1234CAFE),     bus(0,0,0,0), z);
      add(ldx(32'h500, 2'd1, SZ_B, 1'b1, 5'd3),       bus(0,1,0,0), ereq(1, 4'b1100, 32'h400, 32'hCAFECAFE, 0));
      add(nop(),                                      bus(0,1,0,0), ereq(0, 4'hF, 32'h500, 32'h0, 1));
      add(nop(),                                      bus(0,0,1,32'h0000F700), eout(5'd3, 32'h000000F7, 0));
      add({4'b1101, 32'h600, 2'd0, SZ_W, 1'b0, 32'h0, 5'd4}, bus(0,0,0,0), z);
      add(ldx(32'h600, 2'd3, SZ_B, 1'b0, 5'd10),      bus(0,0,0,0), z);
      add(alu(32'h77, 5'd11),                         bus(0,1,0,0), ereq(0, 4'hF, 32'h600, 32'h0, 1));
      add(alu(32'h77, 5'd11),                         bus(1,0,1,32'h85000000), eout(5'd10, 32'hFFFFFF85, 0));
      add(alu(32'h77, 5'd11),                         bus(1,0,0,32'h12345678), eout(5'd10, 32'hFFFFFF85, 0));
      add(alu(32'h77, 5'd11),                         bus(1,0,0,32'h12345678), eout(5'd10, 32'hFFFFFF85, 0));
      add(alu(32'h77, 5'd11),                         bus(0,0,0,32'h12345678), eout(5'd10, 32'hFFFFFF85, 0));
      add(ldx(32'h700, 2'd0, SZ_W, 1'b0, 5'd12),      bus(0,0,0,0), eout(5'd11, 32'h77, 0));
      add(nop(),                                      bus(0,1,0,0), ereq(0, 4'hF, 32'h700, 32'h0, 1));
      add(nop(),                                      bus(0,0,0,0), eout(5'd0, 32'h0, 1));

      reset_n = 1'b0;
      drive(nop(), bus(0,0,0,0));
      repeat (2) @(negedge clk);
      #1 chk_all(-1, z);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].x, vecs[i].b);
         #1 chk_all(i, vecs[i].e);
      end

      // reset while a load waits for rvalid: late rvalid must not surface
      @(negedge clk);
      reset_n = 1'b0;
      drive(nop(), bus(0,0,0,0));
      @(negedge clk);
      reset_n = 1'b1;
      drive(nop(), bus(0,0,1,32'hFFFFFFFF));
      #1 chk_all(100, z);
      @(negedge clk);
      drive(nop(), bus(0,0,0,0));
      #1 chk_all(101, z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
